// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: walks a binary row select, debounces active-low columns on a
// slow scan tick, and publishes one valid/ack key event per physical press.
module keypad_scan_ctrl #(
    parameter int ROWS       = 4,
    parameter int COLS       = 3,
    parameter int SEL_W      = 3,
    parameter int CODE_W     = 4,
    parameter int SCAN_DIV   = 13,
    parameter int DEBOUNCE_N = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [COLS-1:0]   column_i,
    input  logic              key_ack_i,
    output logic [SEL_W-1:0]  sel_o,
    output logic [CODE_W-1:0] key_code_o,
    output logic              key_valid_o,
    output logic              key_held_o,
    output logic              overrun_o
);

    localparam int COL_W = $clog2(COLS);
    localparam int LC_W  = $clog2(COLS + 1);
    localparam int CNT_W = $clog2(DEBOUNCE_N + 1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;

    logic [COLS-1:0]     colMeta_q, colSync_q;
    logic [SCAN_DIV-1:0] prescaler_q;
    logic [1:0]          state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d, nextSel;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cntInc;
    logic [COL_W-1:0]    candCol_q, candCol_d;
    logic [CODE_W-1:0]   keyCode_q, keyCode_d, acceptCode;
    logic                keyValid_q, keyValid_d;
    logic                overrun_q, overrun_d;
    logic                tick, accept, oneLow, anyLow;
    logic [LC_W-1:0]     lowCount;
    logic [COL_W-1:0]    sampleCol;

    // Synchronizer idles at all ones so reset looks like "no key pressed".
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            colMeta_q   <= '1;
            colSync_q   <= '1;
            prescaler_q <= '0;
        end else begin
            colMeta_q   <= column_i;
            colSync_q   <= colMeta_q;
            prescaler_q <= prescaler_q + 1'b1;
        end
    end

    assign tick = &prescaler_q;

    // Column index counts from the MSB, so bit b maps to column COLS-1-b.
    always_comb begin
        lowCount  = '0;
        sampleCol = '0;
        for (int b = 0; b < COLS; b++) begin
            if (!colSync_q[b]) begin
                lowCount  = lowCount + 1'b1;
                sampleCol = COL_W'(COLS - 1 - b);
            end
        end
    end

    assign oneLow     = (lowCount == LC_W'(1));
    assign anyLow     = ~&colSync_q;
    assign cntInc     = cnt_q + 1'b1;
    assign nextSel    = (sel_q == SEL_W'(ROWS - 1)) ? '0 : sel_q + 1'b1;
    assign acceptCode = CODE_W'(sel_q) * CODE_W'(COLS) + CODE_W'(sampleCol);

    // The same counter debounces the press in DEBOUNCE and the release in HOLD.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        candCol_d = candCol_q;
        accept    = 1'b0;
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (oneLow) begin
                        candCol_d = sampleCol;
                        if (DEBOUNCE_N == 1) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        sel_d = nextSel;
                    end
                end
                ST_DEBOUNCE: begin
                    if (oneLow && sampleCol == candCol_q) begin
                        if (cntInc == CNT_W'(DEBOUNCE_N)) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            cnt_d = cntInc;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_SCAN;
                    end
                end
                ST_HOLD: begin
                    if (anyLow) begin
                        cnt_d = '0;
                    end else if (cntInc == CNT_W'(DEBOUNCE_N)) begin
                        cnt_d   = '0;
                        sel_d   = nextSel;
                        state_d = ST_SCAN;
                    end else begin
                        cnt_d = cntInc;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end
            endcase
        end
    end

    // A simultaneous accept beats the acknowledge, but still clears overrun.
    always_comb begin
        keyCode_d  = accept ? acceptCode : keyCode_q;
        keyValid_d = accept | (keyValid_q & ~key_ack_i);
        if (key_ack_i) begin
            overrun_d = 1'b0;
        end else if (accept) begin
            overrun_d = overrun_q | keyValid_q;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_SCAN;
            sel_q      <= '0;
            cnt_q      <= '0;
            candCol_q  <= '0;
            keyCode_q  <= '1;
            keyValid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            candCol_q  <= candCol_d;
            keyCode_q  <= keyCode_d;
            keyValid_q <= keyValid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign sel_o       = sel_q;
    assign key_code_o  = keyCode_q;
    assign key_valid_o = keyValid_q;
    assign key_held_o  = (state_q == ST_HOLD);
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: directed keypad scenarios then random press/bounce
// episodes, each scan tick compared against a tick-level behavioural keypad model.
module tb_keypad_scan_ctrl;

    localparam int ROWS       = 4;
    localparam int COLS       = 3;
    localparam int SEL_W      = 3;
    localparam int CODE_W     = 4;
    localparam int SCAN_DIV   = 2;
    localparam int DEBOUNCE_N = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [COLS-1:0]   column = '1;
    logic              keyAck = 1'b0;
    logic [SEL_W-1:0]  sel;
    logic [CODE_W-1:0] keyCode;
    logic              keyValid, keyHeld, overrun;

    int nChecks = 0;
    int nFails  = 0;

    // Model: the row being looked at, how long the current candidate has been seen,
    // whether a key is being held, and how long the pad has been quiet.
    int mRow, mPressRun, mCandCode, mQuiet, mCode;
    bit mHolding, mValid, mOverrun;

    keypad_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SEL_W(SEL_W), .CODE_W(CODE_W),
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE_N(DEBOUNCE_N)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .column_i   (column),
        .key_ack_i  (keyAck),
        .sel_o      (sel),
        .key_code_o (keyCode),
        .key_valid_o(keyValid),
        .key_held_o (keyHeld),
        .overrun_o  (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, " sel"},      32'(sel),      32'(mRow));
        checkValue({tag, " code"},     32'(keyCode),  32'(mCode));
        checkValue({tag, " valid"},    32'(keyValid), 32'(mValid));
        checkValue({tag, " held"},     32'(keyHeld),  32'(mHolding));
        checkValue({tag, " overrun"},  32'(overrun),  32'(mOverrun));
    endtask

    task automatic modelReset();
        mRow = 0; mPressRun = 0; mCandCode = 0; mQuiet = 0;
        mCode = (1 << CODE_W) - 1;
        mHolding = 0; mValid = 0; mOverrun = 0;
    endtask

    task automatic modelTick(input logic [COLS-1:0] sample, input bit ackNow);
        int lows = 0;
        int col = 0;
        int code;
        bit accepted = 0;
        for (int b = 0; b < COLS; b++) begin
            if (!sample[b]) begin
                lows++;
                col = COLS - 1 - b;
            end
        end
        code = mRow * COLS + col;
        if (mHolding) begin
            mQuiet = (lows == 0) ? mQuiet + 1 : 0;
            if (mQuiet == DEBOUNCE_N) begin
                mHolding = 0;
                mRow = (mRow + 1) % ROWS;
            end
        end else if (mPressRun == 0) begin
            if (lows == 1) begin
                mCandCode = code;
                mPressRun = 1;
            end else begin
                mRow = (mRow + 1) % ROWS;
            end
        end else begin
            mPressRun = (lows == 1 && code == mCandCode) ? mPressRun + 1 : 0;
        end
        if (mPressRun == DEBOUNCE_N) begin
            accepted = 1; mPressRun = 0; mHolding = 1; mQuiet = 0;
        end
        if (accepted) begin
            mCode = mCandCode;
            mOverrun = ackNow ? 1'b0 : (mOverrun | mValid);
            mValid = 1;
        end else if (ackNow) begin
            mValid = 0; mOverrun = 0;
        end
    endtask

    // One scan interval: column set right after a tick is what the next tick sees.
    // ackMode 1 pulses ack mid-interval, ackMode 2 lands it on the tick edge itself.
    task automatic applyStimulus(input logic [COLS-1:0] col, input int ackMode,
                                 input string tag);
        column = col;
        for (int i = 0; i < 4; i++) begin
            keyAck = (ackMode == 1 && i == 0) || (ackMode == 2 && i == 3);
            @(posedge clk);
            #1;
            if (ackMode == 1 && i == 0) begin
                mValid = 0; mOverrun = 0;
            end
        end
        keyAck = 1'b0;
        modelTick(col, ackMode == 2);
        checkOutput(tag);
    endtask

    task automatic doReset(input string tag);
        reset = 1'b1;
        #2;
        modelReset();
        checkOutput(tag);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitRow(input int row);
        for (int i = 0; i < 12 && !(mRow == row && !mHolding && mPressRun == 0); i++)
            applyStimulus(3'b111, 0, "idle");
        checkValue("waitRow reached", 32'(mRow), 32'(row));
    endtask

    initial begin
        logic [COLS-1:0] patterns [8] = '{3'b111, 3'b011, 3'b101, 3'b110,
                                          3'b111, 3'b001, 3'b011, 3'b110};
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] idle scan");
        for (int i = 0; i < 5; i++) applyStimulus(3'b111, 0, "idle scan");
        checkValue("wrap sel", 32'(sel), 32'(1));

        $display("[TB] press code 7 and release");
        waitRow(2);
        for (int i = 0; i < 5; i++) applyStimulus(3'b101, 0, "press7");
        checkValue("press7 code", 32'(keyCode), 32'(7));
        checkValue("press7 held", 32'(keyHeld), 32'(1));
        for (int i = 0; i < 2; i++) applyStimulus(3'b111, 0, "release7");
        checkValue("release7 still held", 32'(keyHeld), 32'(1));
        applyStimulus(3'b111, 0, "release7");
        checkValue("release7 held", 32'(keyHeld), 32'(0));
        checkValue("release7 sel", 32'(sel), 32'(3));

        $display("[TB] bounce");
        applyStimulus(3'b111, 1, "ack");
        applyStimulus(3'b110, 0, "bounce");
        applyStimulus(3'b110, 0, "bounce");
        applyStimulus(3'b111, 0, "bounce");
        checkValue("bounce valid", 32'(keyValid), 32'(0));
        checkValue("bounce held", 32'(keyHeld), 32'(0));

        $display("[TB] overrun");
        waitRow(0);
        for (int i = 0; i < 3; i++) applyStimulus(3'b011, 0, "press0");
        checkValue("press0 code", 32'(keyCode), 32'(0));
        for (int i = 0; i < 3; i++) applyStimulus(3'b111, 0, "release0");
        for (int i = 0; i < 3; i++) applyStimulus(3'b110, 0, "press5");
        checkValue("press5 code", 32'(keyCode), 32'(5));
        checkValue("press5 overrun", 32'(overrun), 32'(1));
        for (int i = 0; i < 3; i++) applyStimulus(3'b111, 0, "release5");
        applyStimulus(3'b111, 1, "ack5");
        checkValue("ack5 valid", 32'(keyValid), 32'(0));
        checkValue("ack5 overrun", 32'(overrun), 32'(0));
        checkValue("ack5 code kept", 32'(keyCode), 32'(5));

        $display("[TB] two columns low");
        for (int i = 0; i < 10; i++) applyStimulus(3'b001, 0, "double");
        checkValue("double valid", 32'(keyValid), 32'(0));

        $display("[TB] reset in hold and debounce");
        waitRow(1);
        for (int i = 0; i < 4; i++) applyStimulus(3'b101, 0, "hold");
        doReset("reset in hold");
        for (int i = 0; i < 2; i++) applyStimulus(3'b101, 0, "debounce");
        doReset("reset in debounce");

        $display("[TB] ack coincident with accept");
        for (int i = 0; i < 3; i++) applyStimulus(3'b011, 0, "pressA");
        for (int i = 0; i < 3; i++) applyStimulus(3'b111, 0, "releaseA");
        for (int i = 0; i < 2; i++) applyStimulus(3'b110, 0, "pressB");
        applyStimulus(3'b110, 2, "pressB ack");
        checkValue("coincident valid", 32'(keyValid), 32'(1));
        checkValue("coincident overrun", 32'(overrun), 32'(0));
        checkValue("coincident code", 32'(keyCode), 32'(5));

        $display("[TB] random episodes");
        for (int e = 0; e < 60; e++) begin
            logic [COLS-1:0] pat;
            int len;
            pat = patterns[$urandom_range(0, 7)];
            len = $urandom_range(1, 5);
            for (int t = 0; t < len; t++) begin
                int a;
                a = $urandom_range(0, 7);
                applyStimulus(pat, (a <= 2) ? a : 0, "random");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
